vga_sprite_display: RTL and testbench
=====================================

Name: vga_sprite_display

Overview:
- Pixel-stage consumer of the VGA timing generator's hpos/vpos/display_on/hsync/vsync outputs; sits between the timing generator and the board RGB/sync pins.
- Overlays one SPRITE_W x SPRITE_H monochrome sprite at a frame-latched position.
- Fetches one bitmap row per line from an external synchronous ROM during horizontal blanking.
- Delays sync/display_on by the same 2-stage pipeline as RGB; the timing generator runs with N_MIXER_PIPE_STAGES=2.

Parameters:
HPOS_WIDTH, 10, width of hpos/sprite_x
VPOS_WIDTH, 10, width of vpos/sprite_y
H_DISPLAY, 640, visible pixels per line; also the row-fetch trigger column
H_MAX, 799, last hpos of a line
V_DISPLAY, 480, visible lines
V_MAX, 524, last vpos of a frame
SPRITE_W, 16, sprite width in pixels = rom_data width
SPRITE_H, 16, sprite height in lines
ROW_AW, 4, rom_addr width, must satisfy 2**ROW_AW >= SPRITE_H
RGB_WIDTH, 3, colour width

Ports:
clk  in  1  pixel-domain clock
reset_n  in  1  asynchronous, active-low reset
enable  in  1  pixel strobe; same signal that advances the timing generator
hpos  in  HPOS_WIDTH  timing generator horizontal position
vpos  in  VPOS_WIDTH  timing generator vertical position
display_on  in  1  timing generator visible-area flag
hsync  in  1  timing generator hsync (active low)
vsync  in  1  timing generator vsync (active low)
sprite_x  in  HPOS_WIDTH  requested sprite left column
sprite_y  in  VPOS_WIDTH  requested sprite top line
fg_rgb  in  RGB_WIDTH  colour for set sprite bits
bg_rgb  in  RGB_WIDTH  colour for the rest of the visible area
rom_rd  out  1  row read strobe, one clk wide
rom_addr  out  ROW_AW  sprite row index
rom_data  in  SPRITE_W  row bitmap, valid on the clk after rom_rd; MSB is the leftmost pixel
rgb  out  RGB_WIDTH  pixel colour
hsync_o  out  1  hsync delayed 2 enable-stages
vsync_o  out  1  vsync delayed 2 enable-stages
display_on_o  out  1  display_on delayed 2 enable-stages

Behaviour:
- Reset (reset_n low, async): rgb=0, hsync_o=0, vsync_o=0, display_on_o=0, rom_rd=0, rom_addr=0; all pipeline registers 0; x_lat=y_lat=0; FSM in IDLE.
- Reset mid-line or mid-fetch aborts the fetch and drawing immediately; no rom_rd is issued after release until the next fetch trigger.
- Frame latch: on enable with vpos==V_DISPLAY and hpos==0, x_lat<=sprite_x and y_lat<=sprite_y. Changes at other times take effect in the next frame only, so the sprite never tears.
- Target line: tl = 0 if vpos==V_MAX, else vpos+1. Row index ly = tl - y_lat. The row is in range when tl >= y_lat and ly < SPRITE_H.
- FSM states IDLE, FETCH, CAPTURE, ARMED, DRAW.
  - Fetch trigger: enable and hpos==H_DISPLAY. If ly is in range, go to FETCH from any state; this aborts DRAW, so the sprite is clipped at the right edge. Otherwise go to IDLE.
  - FETCH (1 clk, ignores enable): rom_rd=1, rom_addr=ly; then CAPTURE.
  - CAPTURE (1 clk): row_buf<=rom_data; then ARMED.
  - ARMED: on enable with hpos==x_lat and hpos<H_DISPLAY, go to DRAW with col=0.
  - DRAW: on each enable the pixel bit is row_buf[SPRITE_W-1-col] and col increments. After col==SPRITE_W-1, go to IDLE.
  - If x_lat >= H_DISPLAY, ARMED stays until the next fetch trigger and nothing is drawn.
- Pipeline, advancing only on enable:
  - Stage 1 registers hit (DRAW and bit set), display_on, hsync, vsync.
  - Stage 2 registers rgb = !disp1 ? 0 : (hit1 ? fg_rgb : bg_rgb) and copies the sync/display flags to the outputs.
  - Latency is exactly 2 enable-strobes from the input sample to the output.
- Simultaneous frame latch and fetch trigger cannot occur (they fire in different hpos columns).
- enable low holds every register except the FETCH/CAPTURE sequencing.

Optional Feature:
- SPRITE_MIRROR_EN
  - Defined: adds input port mirror (1 bit), latched with x_lat/y_lat. When the latched value is 1, DRAW uses row_buf[col] (LSB leftmost).
  - Undefined: the port is absent and the MSB is always the leftmost pixel.

Test Plan:
- Reset: hold reset_n=0 for 5 clk with enable=1 -> all outputs 0, rom_rd never asserted; release -> first rom_rd only at a fetch trigger.
- Latency: sprite_y=600 (off-screen), enable=1 every clk, drive hsync 1->0 at hpos 656 -> hsync_o falls exactly 2 enables later; rgb equals bg_rgb throughout the visible area, 0 in blanking.
- Basic draw: sprite_x=100, sprite_y=50, rom returns 16'h8001 for every row -> on lines 50..65, fg_rgb at hpos 100 and 115 (seen 2 enables later), bg elsewhere; exactly 16 rom_rd pulses per frame with addr 0..15.
- Frame latch: change sprite_x 100->200 at line 300 -> the current frame is unchanged; the next frame draws at 200.
- Right clip: sprite_x=630, rom=16'hFFFF -> fg at hpos 630..639 only; rgb=0 from 640; the next line's fetch still occurs at hpos 640.
- Mirror (SPRITE_MIRROR_EN): mirror=1, rom=16'h8000, sprite_x=100 -> fg only at hpos 115.

Source files
------------

// File: rtl/vga_sprite_display.sv
// vga_sprite_display: overlays one monochrome ROM sprite on the VGA pixel stream with a 2-stage RGB/sync pipeline.
// Optional horizontal mirroring is built when SPRITE_MIRROR_EN is defined.
module vga_sprite_display #(
    parameter int HPOS_WIDTH = 10,
    parameter int VPOS_WIDTH = 10,
    parameter int H_DISPLAY  = 640,
    parameter int H_MAX      = 799,
    parameter int V_DISPLAY  = 480,
    parameter int V_MAX      = 524,
    parameter int SPRITE_W   = 16,
    parameter int SPRITE_H   = 16,
    parameter int ROW_AW     = 4,
    parameter int RGB_WIDTH  = 3
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  enable,
    input  logic [HPOS_WIDTH-1:0] hpos,
    input  logic [VPOS_WIDTH-1:0] vpos,
    input  logic                  display_on,
    input  logic                  hsync,
    input  logic                  vsync,
    input  logic [HPOS_WIDTH-1:0] sprite_x,
    input  logic [VPOS_WIDTH-1:0] sprite_y,
    input  logic [RGB_WIDTH-1:0]  fg_rgb,
    input  logic [RGB_WIDTH-1:0]  bg_rgb,
`ifdef SPRITE_MIRROR_EN
    input  logic                  mirror,
`endif
    output logic                  rom_rd,
    output logic [ROW_AW-1:0]     rom_addr,
    input  logic [SPRITE_W-1:0]   rom_data,
    output logic [RGB_WIDTH-1:0]  rgb,
    output logic                  hsync_o,
    output logic                  vsync_o,
    output logic                  display_on_o
);
    localparam int COL_W = (SPRITE_W > 1) ? $clog2(SPRITE_W) : 1;

    typedef enum logic [2:0] {IDLE, FETCH, CAPTURE, ARMED, DRAW} state_t;

    state_t                r_state, w_next;
    logic [HPOS_WIDTH-1:0] r_x_lat;
    logic [VPOS_WIDTH-1:0] r_y_lat;
    logic [SPRITE_W-1:0]   r_row_buf;
    logic [COL_W-1:0]      r_col, w_col_next, w_pix_col;
    logic                  r_hit1, r_disp1, r_hs1, r_vs1;
    logic [VPOS_WIDTH-1:0] w_tl, w_ly;
    logic                  w_in_range, w_trigger, w_start, w_latch, w_bit, w_hit, w_mir;

`ifdef SPRITE_MIRROR_EN
    logic r_mirror;
    assign w_mir = r_mirror;
`else
    assign w_mir = 1'b0;
`endif

    assign w_tl       = (vpos == VPOS_WIDTH'(V_MAX)) ? '0 : vpos + 1'b1;
    assign w_ly       = w_tl - r_y_lat;
    assign w_in_range = (w_tl >= r_y_lat) && (w_ly < VPOS_WIDTH'(SPRITE_H));
    assign w_trigger  = enable && (hpos == HPOS_WIDTH'(H_DISPLAY));
    assign w_latch    = enable && (vpos == VPOS_WIDTH'(V_DISPLAY)) && (hpos == '0);
    assign w_start    = (r_state == ARMED) && enable && (hpos == r_x_lat) && (hpos < HPOS_WIDTH'(H_DISPLAY));
    // The start pixel is column 0 itself, so the sprite's left edge lands exactly on x_lat.
    assign w_pix_col  = (r_state == DRAW) ? r_col : '0;
    assign w_bit      = w_mir ? r_row_buf[w_pix_col] : r_row_buf[COL_W'(SPRITE_W-1) - w_pix_col];
    assign w_hit      = ((r_state == DRAW) || w_start) && w_bit;
    assign rom_rd     = (r_state == FETCH);

    always_comb begin
        w_next     = r_state;
        w_col_next = r_col;
        case (r_state)
            FETCH:   w_next = CAPTURE;
            CAPTURE: w_next = ARMED;
            ARMED: if (w_start) begin
                w_next     = DRAW;
                w_col_next = COL_W'(1);
            end
            DRAW: if (enable) begin
                w_col_next = r_col + 1'b1;
                if (r_col == COL_W'(SPRITE_W-1)) w_next = IDLE;
            end
            default: ;
        endcase
        // The fetch trigger overrides everything, clipping a sprite still drawing at the right edge.
        if (w_trigger) w_next = w_in_range ? FETCH : IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= IDLE;
            r_col        <= '0;
            r_x_lat      <= '0;
            r_y_lat      <= '0;
            r_row_buf    <= '0;
            rom_addr     <= '0;
            r_hit1       <= 1'b0;
            r_disp1      <= 1'b0;
            r_hs1        <= 1'b0;
            r_vs1        <= 1'b0;
            rgb          <= '0;
            hsync_o      <= 1'b0;
            vsync_o      <= 1'b0;
            display_on_o <= 1'b0;
`ifdef SPRITE_MIRROR_EN
            r_mirror     <= 1'b0;
`endif
        end else begin
            r_state <= w_next;
            r_col   <= w_col_next;
            if (w_trigger && w_in_range) rom_addr <= w_ly[ROW_AW-1:0];
            if (r_state == CAPTURE) r_row_buf <= rom_data;
            if (w_latch) begin
                r_x_lat  <= sprite_x;
                r_y_lat  <= sprite_y;
`ifdef SPRITE_MIRROR_EN
                r_mirror <= mirror;
`endif
            end
            if (enable) begin
                r_hit1       <= w_hit;
                r_disp1      <= display_on;
                r_hs1        <= hsync;
                r_vs1        <= vsync;
                rgb          <= !r_disp1 ? '0 : (r_hit1 ? fg_rgb : bg_rgb);
                hsync_o      <= r_hs1;
                vsync_o      <= r_vs1;
                display_on_o <= r_disp1;
            end
        end
    end
endmodule

// File: tb/tb_vga_sprite_display.sv
// tb_vga_sprite_display: scoreboard bench for vga_sprite_display on a reduced raster.
module tb_vga_sprite_display;
    localparam int H_D = 64, H_M = 99, V_D = 40, V_M = 49;
    localparam int HS0 = 70, HS1 = 80, VS0 = 43, VS1 = 45;

    logic        clk = 1'b0;
    logic        reset_n, enable, display_on, hsync, vsync;
    logic [9:0]  hpos, vpos, sprite_x, sprite_y;
    logic [2:0]  fg_rgb, bg_rgb, rgb;
    logic        rom_rd, hsync_o, vsync_o, display_on_o;
    logic [3:0]  rom_addr;
    logic [15:0] rom_data = '0;
    logic [15:0] pat [16];
    logic        mir, m_mir, rand_en;
    logic [9:0]  m_x, m_y;
    logic [5:0]  sq [$];
    logic [3:0]  rq [$];
    int          checks = 0, errors = 0;

    always #5 clk = ~clk;

    assign display_on = (hpos < H_D) && (vpos < V_D);
    assign hsync      = !((hpos >= HS0) && (hpos < HS1));
    assign vsync      = !((vpos >= VS0) && (vpos < VS1));

    always @(posedge clk) if (rom_rd) rom_data <= pat[rom_addr];

    vga_sprite_display #(
        .HPOS_WIDTH(10), .VPOS_WIDTH(10), .H_DISPLAY(H_D), .H_MAX(H_M),
        .V_DISPLAY(V_D), .V_MAX(V_M), .SPRITE_W(16), .SPRITE_H(16), .ROW_AW(4), .RGB_WIDTH(3)
    ) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .hpos(hpos), .vpos(vpos),
        .display_on(display_on), .hsync(hsync), .vsync(vsync),
        .sprite_x(sprite_x), .sprite_y(sprite_y), .fg_rgb(fg_rgb), .bg_rgb(bg_rgb),
`ifdef SPRITE_MIRROR_EN
        .mirror(mir),
`endif
        .rom_rd(rom_rd), .rom_addr(rom_addr), .rom_data(rom_data),
        .rgb(rgb), .hsync_o(hsync_o), .vsync_o(vsync_o), .display_on_o(display_on_o)
    );

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [5:0] expect_px();
        int   r, c;
        logic hit;
        logic [2:0] e;
        hit = 1'b0;
        r   = int'(vpos) - int'(m_y);
        c   = int'(hpos) - int'(m_x);
        if (r >= 0 && r < 16 && c >= 0 && c < 16 && hpos < H_D)
            hit = m_mir ? pat[r][c] : pat[r][15-c];
        e = !display_on ? 3'd0 : (hit ? fg_rgb : bg_rgb);
        return {e, hsync, vsync, display_on};
    endfunction

    task automatic step();
        int         tl;
        logic [5:0] exp_px;
        @(posedge clk);
        #1;
        if (enable) begin
            sq.push_back(expect_px());
            if (sq.size() > 1) begin
                exp_px = sq.pop_front();
                chk("pixel", {10'd0, rgb, hsync_o, vsync_o, display_on_o}, {10'd0, exp_px});
            end
            if (hpos == H_D) begin
                tl = (vpos == V_M) ? 0 : int'(vpos) + 1;
                if (tl >= int'(m_y) && tl - int'(m_y) < 16) rq.push_back(4'(tl - int'(m_y)));
            end
            if (vpos == V_D && hpos == 0) begin
                m_x   = sprite_x;
                m_y   = sprite_y;
`ifdef SPRITE_MIRROR_EN
                m_mir = mir;
`else
                m_mir = 1'b0;
`endif
            end
            if (hpos == H_M) begin
                hpos = '0;
                vpos = (vpos == V_M) ? '0 : vpos + 1'b1;
            end else hpos = hpos + 1'b1;
        end
        if (rom_rd) begin
            if (rq.size() == 0) chk("rom_rd_unexpected", {15'd0, rom_rd}, 16'd0);
            else chk("rom_addr", {12'd0, rom_addr}, {12'd0, rq.pop_front()});
        end
        enable = rand_en ? 1'($urandom_range(0, 1)) : 1'b1;
    endtask

    task automatic run_to(input int h_t, input int v_t);
        int n = 0;
        do begin
            step();
            n++;
        end while (!(int'(hpos) == h_t && int'(vpos) == v_t) && n < 30000);
        chk("run_to_reached", {15'd0, int'(hpos) == h_t && int'(vpos) == v_t}, 16'd1);
    endtask

    task automatic run_until_rd();
        int n = 0;
        do begin
            step();
            n++;
        end while (!rom_rd && n < 10000);
        chk("fetch_seen", {15'd0, rom_rd}, 16'd1);
    endtask

    task automatic do_reset();
        enable  = 1'b1;
        reset_n = 1'b0;
        #1;
        chk("async_reset_out", {9'd0, rgb, hsync_o, vsync_o, display_on_o, rom_rd}, 16'd0);
        repeat (5) begin
            @(posedge clk);
            #1;
            chk("reset_out", {9'd0, rgb, hsync_o, vsync_o, display_on_o, rom_rd}, 16'd0);
            chk("reset_addr", {12'd0, rom_addr}, 16'd0);
        end
        sq.delete();
        rq.delete();
        hpos    = '0;
        vpos    = 10'(V_D);
        m_x     = '0;
        m_y     = '0;
        m_mir   = 1'b0;
        reset_n = 1'b1;
    endtask

    task automatic set_pat(input logic [15:0] base, input logic [15:0] stride);
        for (int i = 0; i < 16; i++) pat[i] = base ^ (16'(i) * stride);
    endtask

    initial begin
        reset_n  = 1'b1;
        enable   = 1'b1;
        rand_en  = 1'b0;
        mir      = 1'b0;
        hpos     = '0;
        vpos     = 10'(V_D);
        sprite_x = '0;
        sprite_y = 10'd60;
        fg_rgb   = 3'b101;
        bg_rgb   = 3'b010;
        set_pat(16'h0000, 16'h0000);
        #2;
        do_reset();
        // Off-screen sprite: background only, sync latency visible through the scoreboard.
        run_to(0, V_D);
        chk("rom_idle_frame", 16'(rq.size()), 16'd0);
        // Basic draw with bits at both edges of the sprite.
        sprite_x = 10'd10;
        sprite_y = 10'd5;
        set_pat(16'h8001, 16'h0000);
        run_to(0, V_D);
        chk("rom_pending_b", 16'(rq.size()), 16'd0);
        // Reset in the middle of a row fetch.
        run_until_rd();
        do_reset();
        // Position change mid-frame only shows up in the following frame.
        run_to(0, 20);
        sprite_x = 10'd30;
        run_to(0, V_D);
        run_to(0, V_D);
        // Right-edge clipping.
        sprite_x = 10'd58;
        set_pat(16'hFFFF, 16'h0000);
        run_to(0, V_D);
        chk("rom_pending_d", 16'(rq.size()), 16'd0);
        // Sparse enable with a distinct bitmap per row.
        rand_en  = 1'b1;
        sprite_x = 10'd20;
        sprite_y = 10'd10;
        set_pat(16'hA5C3, 16'h1111);
        run_to(0, V_D);
        rand_en  = 1'b0;
        chk("rom_pending_e", 16'(rq.size()), 16'd0);
`ifdef SPRITE_MIRROR_EN
        mir      = 1'b1;
        sprite_x = 10'd10;
        sprite_y = 10'd5;
        set_pat(16'h8000, 16'h0000);
        run_to(0, V_D);
        run_to(0, V_D);
        mir      = 1'b0;
        chk("rom_pending_f", 16'(rq.size()), 16'd0);
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
